// File: rtl/fountain_pkg.sv
// Shared fountain-code definitions: block geometry, decoder states and pivot row layout.
// Also used by the encoder, so the coefficient mask conventions stay identical on both sides.
package fountain_pkg;

    localparam int unsigned FOUNTAIN_K = 8;
    localparam int unsigned FOUNTAIN_W = 8;

    typedef enum logic [1:0] {
        ACCEPT,
        ELIM,
        BACKSUB,
        OUTPUT
    } dec_state_t;

    // Bit j of coef set means source symbol j contributes to sym.
    typedef struct packed {
        logic                  valid;
        logic [FOUNTAIN_K-1:0] coef;
        logic [FOUNTAIN_W-1:0] sym;
    } pivot_row_t;

endpackage

// File: rtl/fountain_v1_decoder_if.sv
// Encoded-symbol input and recovered-symbol output channels of the fountain decoder.
interface fountain_v1_decoder_if
    import fountain_pkg::*;
#(
    parameter int unsigned K = FOUNTAIN_K,
    parameter int unsigned W = FOUNTAIN_W
);
    logic                 in_valid;
    logic                 in_ready;
    logic [K-1:0]         in_coef;
    logic [W-1:0]         in_sym;
    logic                 out_valid;
    logic                 out_ready;
    logic [$clog2(K)-1:0] out_idx;
    logic [W-1:0]         out_sym;

    modport master (
        output in_valid, in_coef, in_sym, out_ready,
        input  in_ready, out_valid, out_idx, out_sym
    );

    modport slave (
        input  in_valid, in_coef, in_sym, out_ready,
        output in_ready, out_valid, out_idx, out_sym
    );

endinterface

// File: rtl/fountain_gf2_row_xor.sv
// Conditional GF(2) row addition: y = a ^ b when en, else y = a.
module fountain_gf2_row_xor #(
    parameter int unsigned K = 8,
    parameter int unsigned W = 8
) (
    input  logic         en,
    input  logic [K-1:0] a_coef,
    input  logic [W-1:0] a_sym,
    input  logic [K-1:0] b_coef,
    input  logic [W-1:0] b_sym,
    output logic [K-1:0] y_coef,
    output logic [W-1:0] y_sym
);

    always_comb begin
        y_coef = a_coef;
        y_sym  = a_sym;
        if (en) begin
            y_coef = a_coef ^ b_coef;
            y_sym  = a_sym ^ b_sym;
        end
    end

endmodule

// File: rtl/fountain_v1_decoder.sv
// Online GF(2) Gaussian-elimination fountain decoder with back-substitution and in-order output.
// Optional FOUNTAIN_DEC_STATS_EN adds saturating rx_count/dup_count statistics outputs.
module fountain_v1_decoder
    import fountain_pkg::*;
#(
    parameter int unsigned K = FOUNTAIN_K,
    parameter int unsigned W = FOUNTAIN_W
) (
    input  logic                     clk,
    input  logic                     reset,
    fountain_v1_decoder_if.slave     dec,
    output logic [$clog2(K+1)-1:0]   rank,
    output logic                     done
`ifdef FOUNTAIN_DEC_STATS_EN
    ,
    output logic [15:0]              rx_count,
    output logic [15:0]              dup_count
`endif
);

    localparam int unsigned IDX_W  = $clog2(K);
    localparam int unsigned RANK_W = $clog2(K + 1);
    localparam logic [IDX_W-1:0]  LAST = IDX_W'(K - 1);
    localparam logic [RANK_W-1:0] FULL = RANK_W'(K);

    dec_state_t             state_q, state_d;
    logic [IDX_W-1:0]       cnt_q, cnt_d;
    logic                   stored_q, stored_d;
    logic [K-1:0]           work_coef_q, work_coef_d;
    logic [W-1:0]           work_sym_q, work_sym_d;
    logic [K-1:0]           piv_valid_q, piv_valid_d;
    logic [K-1:0][K-1:0]    piv_coef_q, piv_coef_d;
    logic [K-1:0][W-1:0]    piv_sym_q, piv_sym_d;
    logic [RANK_W-1:0]      rank_q, rank_d;
    logic                   in_ready_q, in_ready_d;
    logic                   done_q, done_d;

    logic                   xor_en;
    logic [K-1:0]           xr_coef;
    logic [W-1:0]           xr_sym;
    logic [W-1:0]           bs_sym;

    // Pivot c has no bits below c, so eliminating column c never re-sets a lower column.
    assign xor_en = (state_q == ELIM) && !stored_q && work_coef_q[cnt_q] && piv_valid_q[cnt_q];

    fountain_gf2_row_xor #(
        .K(K),
        .W(W)
    ) u_row_xor (
        .en     (xor_en),
        .a_coef (work_coef_q),
        .a_sym  (work_sym_q),
        .b_coef (piv_coef_q[cnt_q]),
        .b_sym  (piv_sym_q[cnt_q]),
        .y_coef (xr_coef),
        .y_sym  (xr_sym)
    );

    // Rows above cnt are already reduced to unit rows, so their syms are final source values.
    always_comb begin
        bs_sym = piv_sym_q[cnt_q];
        for (int unsigned j = 0; j < K; j++) begin
            if (j > 32'(cnt_q) && piv_coef_q[cnt_q][j]) begin
                bs_sym = bs_sym ^ piv_sym_q[j];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stored_d    = stored_q;
        work_coef_d = work_coef_q;
        work_sym_d  = work_sym_q;
        piv_valid_d = piv_valid_q;
        piv_coef_d  = piv_coef_q;
        piv_sym_d   = piv_sym_q;
        rank_d      = rank_q;
        done_d      = 1'b0;

        case (state_q)
            ACCEPT: begin
                if (dec.in_valid && in_ready_q) begin
                    work_coef_d = dec.in_coef;
                    work_sym_d  = dec.in_sym;
                    stored_d    = 1'b0;
                    cnt_d       = '0;
                    state_d     = ELIM;
                end
            end
            ELIM: begin
                work_coef_d = xr_coef;
                work_sym_d  = xr_sym;
                if (!stored_q && work_coef_q[cnt_q] && !piv_valid_q[cnt_q]) begin
                    piv_valid_d[cnt_q] = 1'b1;
                    piv_coef_d[cnt_q]  = work_coef_q;
                    piv_sym_d[cnt_q]   = work_sym_q;
                    rank_d             = rank_q + RANK_W'(1);
                    stored_d           = 1'b1;
                end
                if (cnt_q == LAST) begin
                    if (rank_d == FULL) begin
                        state_d = BACKSUB;
                        cnt_d   = LAST;
                    end else begin
                        state_d = ACCEPT;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            BACKSUB: begin
                piv_sym_d[cnt_q]         = bs_sym;
                piv_coef_d[cnt_q]        = '0;
                piv_coef_d[cnt_q][cnt_q] = 1'b1;
                if (cnt_q == '0) begin
                    state_d = OUTPUT;
                end else begin
                    cnt_d = cnt_q - IDX_W'(1);
                end
            end
            OUTPUT: begin
                if (dec.out_ready) begin
                    if (cnt_q == LAST) begin
                        piv_valid_d = '0;
                        rank_d      = '0;
                        done_d      = 1'b1;
                        cnt_d       = '0;
                        state_d     = ACCEPT;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
        endcase

        in_ready_d = (state_d == ACCEPT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ACCEPT;
            cnt_q       <= '0;
            stored_q    <= 1'b0;
            work_coef_q <= '0;
            work_sym_q  <= '0;
            piv_valid_q <= '0;
            piv_coef_q  <= '0;
            piv_sym_q   <= '0;
            rank_q      <= '0;
            in_ready_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stored_q    <= stored_d;
            work_coef_q <= work_coef_d;
            work_sym_q  <= work_sym_d;
            piv_valid_q <= piv_valid_d;
            piv_coef_q  <= piv_coef_d;
            piv_sym_q   <= piv_sym_d;
            rank_q      <= rank_d;
            in_ready_q  <= in_ready_d;
            done_q      <= done_d;
        end
    end

    assign dec.in_ready  = in_ready_q;
    assign dec.out_valid = (state_q == OUTPUT);
    assign dec.out_idx   = (state_q == OUTPUT) ? cnt_q : '0;
    assign dec.out_sym   = (state_q == OUTPUT) ? piv_sym_q[cnt_q] : '0;
    assign rank          = rank_q;
    assign done          = done_q;

`ifdef FOUNTAIN_DEC_STATS_EN
    logic [15:0] rx_count_q, rx_count_d;
    logic [15:0] dup_count_q, dup_count_d;

    always_comb begin
        rx_count_d  = rx_count_q;
        dup_count_d = dup_count_q;
        if (state_q == ACCEPT && dec.in_valid && in_ready_q && rx_count_q != '1) begin
            rx_count_d = rx_count_q + 16'd1;
        end
        if (state_q == ELIM && cnt_q == LAST && !stored_d && dup_count_q != '1) begin
            dup_count_d = dup_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_count_q  <= '0;
            dup_count_q <= '0;
        end else begin
            rx_count_q  <= rx_count_d;
            dup_count_q <= dup_count_d;
        end
    end

    assign rx_count  = rx_count_q;
    assign dup_count = dup_count_q;
`endif

endmodule

// File: tb/tb_fountain_v1_decoder.sv
// Scoreboard bench for fountain_v1_decoder: directed blocks, redundancy, backpressure, reset abort.
module tb_fountain_v1_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rank;
    logic       done;
`ifdef FOUNTAIN_DEC_STATS_EN
    logic [15:0] rx_count;
    logic [15:0] dup_count;
`endif

    fountain_v1_decoder_if #(.K(8), .W(8)) bus ();

    fountain_v1_decoder #(.K(8), .W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .dec       (bus),
        .rank      (rank),
        .done      (done)
`ifdef FOUNTAIN_DEC_STATS_EN
        ,
        .rx_count  (rx_count),
        .dup_count (dup_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] sym;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt    = 0;
    int   total_cnt   = 0;
    int   done_pulses = 0;

    logic [7:0] mix_coef [10] = '{8'h03, 8'h03, 8'h00, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [7:0] mix_sym  [10] = '{8'h01, 8'h01, 8'h55, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    logic [3:0] mix_rank [10] = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: pops one expectation per transfer and checks stability while stalled.
    logic       prev_stall = 1'b0;
    logic [2:0] prev_idx;
    logic [7:0] prev_sym;
    exp_t       e;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (done) done_pulses++;
            if (prev_stall) begin
                check("stall_hold", {bus.out_valid, bus.out_idx, bus.out_sym}, {1'b1, prev_idx, prev_sym});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_out: got idx %0d sym %h expected no output", bus.out_idx, bus.out_sym);
                end else begin
                    e = exp_q.pop_front();
                    check("out_idx", 32'(bus.out_idx), 32'(e.idx));
                    check("out_sym", 32'(bus.out_sym), 32'(e.sym));
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_idx   = bus.out_idx;
            prev_sym   = bus.out_sym;
        end
    end

    task automatic send(input logic [7:0] c, input logic [7:0] s);
        int n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("send_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_coef  = c;
        bus.in_sym   = s;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_coef  = '0;
        bus.in_sym   = '0;
    endtask

    // Non-final symbol: in_ready must return exactly K cycles after the handshake edge.
    task automatic send_acc(input logic [7:0] c, input logic [7:0] s, input logic [3:0] exp_rank);
        int n = 0;
        send(c, s);
        while (!bus.in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_latency", 32'(n), 32'd8);
        check("rank", 32'(rank), 32'(exp_rank));
    endtask

    // Full-rank symbol: first out_valid 2K cycles after the handshake edge.
    task automatic send_full(input logic [7:0] c, input logic [7:0] s);
        int n = 0;
        send(c, s);
        while (!bus.out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("first_out_latency", 32'(n), 32'd16);
        check("rank_full", 32'(rank), 32'd8);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_seen", 32'(done), 32'd1);
        check("block_drained", 32'(exp_q.size()), 32'd0);
        check("rank_cleared", 32'(rank), 32'd0);
        check("ready_at_done", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic identity_block(input logic [7:0] base);
        for (int i = 0; i < 8; i++) exp_q.push_back({3'(i), 8'(base + 8'(i))});
        for (int i = 0; i < 7; i++) send_acc(8'(1 << i), 8'(base + 8'(i)), 4'(i + 1));
        send_full(8'h80, 8'(base + 8'd7));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_coef   = '0;
        bus.in_sym    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_outputs", {bus.out_valid, bus.out_idx, bus.out_sym, rank, done}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", 32'(bus.in_ready), 32'd1);

        identity_block(8'h10);
        wait_done();

        // Back-to-back: mixed block starts in the done cycle, with redundant and zero rows.
        for (int i = 0; i < 8; i++) exp_q.push_back({3'(i), 8'(8'hA0 + 8'(i))});
        for (int i = 0; i < 9; i++) send_acc(mix_coef[i], mix_sym[i], mix_rank[i]);
        send_full(mix_coef[9], mix_sym[9]);
        n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while (!(bus.out_valid && bus.out_idx == 3'd3) && n < 20);
        check("bp_reach_idx3", {31'd0, bus.out_valid && bus.out_idx == 3'd3}, 32'd1);
        bus.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("bp_held_idx", {bus.out_valid, bus.out_idx}, {1'b1, 3'd3});
        bus.out_ready = 1'b1;
        wait_done();
`ifdef FOUNTAIN_DEC_STATS_EN
        check("rx_count", 32'(rx_count), 32'd18);
        check("dup_count", 32'(dup_count), 32'd2);
`endif
        @(posedge clk); #1;

        // Abort a block with reset in the middle of ELIM at rank 7.
        for (int i = 0; i < 7; i++) send_acc(8'(1 << i), 8'(8'h20 + 8'(i)), 4'(i + 1));
        send(8'h80, 8'h27);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_rank", 32'(rank), 32'd0);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_ready_back", 32'(bus.in_ready), 32'd1);

        identity_block(8'h30);
        wait_done();
`ifdef FOUNTAIN_DEC_STATS_EN
        check("rx_after_reset", 32'(rx_count), 32'd8);
        check("dup_after_reset", 32'(dup_count), 32'd0);
`endif
        repeat (3) @(posedge clk);
        #1;
        check("done_pulses", 32'(done_pulses), 32'd3);
        check("no_stray_out", 32'(bus.out_valid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
